// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB-first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_borrow;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  logic w_a0;
  logic w_b0;
  logic w_d;
  logic w_bo;

  // Full-subtractor cell on the current LSBs and the running borrow.
  always_comb begin
    w_a0 = r_a[0];
    w_b0 = r_b[0];
    w_d  = w_a0 ^ w_b0 ^ r_br;
    w_bo = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_cnt       <= '0;
      r_br        <= 1'b0;
      r_borrow    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_br       <= bin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb    <= a[WIDTH-1];
            r_b_msb    <= b[WIDTH-1];
`endif
          end
        end

        S_SHIFT: begin
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_a    <= {1'b0, r_a[WIDTH-1:1]};
          r_b    <= {1'b0, r_b[WIDTH-1:1]};
          r_br   <= w_bo;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            // Final cell: its difference bit is the result MSB, its borrow the carry-out.
            r_borrow    <= w_bo;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf       <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8), hand-computed vectors.
// Overflow checks are included when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         busy;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .busy      (busy)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one operand set for a single cycle, then waits (bounded) for out_valid.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                       output int lat);
    a        = ta;
    b        = tb_;
    bin      = tbin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  int           lat;
  logic [W-1:0] lo_diff;
  logic [W-1:0] hold_diff;
  logic         hold_borrow;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);

    // 0x35 - 0x12 = 0x23, latency WIDTH
    out_ready = 1'b1;
    a = 8'h35; b = 8'h12; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("acc_in_ready_low", in_ready, 0);
    check("acc_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("op1_latency", lat, 8);
    check("op1_diff", diff, 8'h23);
    check("op1_borrow", borrow, 0);
    check("op1_busy_done", busy, 1);
    tick();
    check("op1_in_ready_back", in_ready, 1);
    check("op1_out_valid_low", out_valid, 0);
    check("op1_busy_low", busy, 0);

    // 0x00 - 0x01 = 0xFF, borrow
    do_op(8'h00, 8'h01, 1'b0, lat);
    check("op2_latency", lat, 8);
    check("op2_diff", diff, 8'hFF);
    check("op2_borrow", borrow, 1);
`ifdef SERIAL_SUB_OVF_EN
    check("op2_ovf", ovf, 0);
`endif
    tick();

    // 0x10 - 0x10 - 1 = 0xFF, borrow
    do_op(8'h10, 8'h10, 1'b1, lat);
    check("op3_diff", diff, 8'hFF);
    check("op3_borrow", borrow, 1);
    tick();

    // Chained 16-bit: 0x0100 - 0x0001 = 0x00FF
    do_op(8'h00, 8'h01, 1'b0, lat);
    lo_diff = diff;
    check("chain_lo_borrow", borrow, 1);
    tick();
    do_op(8'h01, 8'h00, 1'b1, lat);
    check("chain_word", {diff, lo_diff}, 16'h00FF);
    check("chain_hi_borrow", borrow, 0);
    tick();

    // Back-pressure with ignored in_valid pulses in SHIFT and DONE: 0x5C - 0x2A = 0x32
    out_ready = 1'b0;
    a = 8'h5C; b = 8'h2A; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    a = 8'hFF; b = 8'h00; bin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 2;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_latency", lat, 8);
    check("bp_diff", diff, 8'h32);
    check("bp_borrow", borrow, 0);
    hold_diff   = diff;
    hold_borrow = borrow;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_diff", diff, hold_diff);
      check("bp_hold_borrow", borrow, hold_borrow);
      check("bp_hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    tick();
    tick();
    check("bp_no_accept_busy", busy, 0);
    check("bp_no_accept_valid", out_valid, 0);

    // Reset at shift 4 of 8
    a = 8'hC3; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow, 0);
    check("abort_in_ready", in_ready, 1);
    tick();
    check("abort_stays_idle", out_valid, 0);
    do_op(8'h0A, 8'h03, 1'b0, lat);
    check("post_abort_latency", lat, 8);
    check("post_abort_diff", diff, 8'h07);
    check("post_abort_borrow", borrow, 0);
    tick();

    // Signed-boundary vectors
    do_op(8'h80, 8'h01, 1'b0, lat);
    check("s1_diff", diff, 8'h7F);
    check("s1_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("s1_ovf", ovf, 1);
`endif
    tick();
    do_op(8'h7F, 8'hFF, 1'b0, lat);
    check("s2_diff", diff, 8'h80);
    check("s2_borrow", borrow, 1);
`ifdef SERIAL_SUB_OVF_EN
    check("s2_ovf", ovf, 1);
`endif
    tick();
    do_op(8'hFF, 8'hFF, 1'b1, lat);
    check("s3_diff", diff, 8'hFF);
    check("s3_borrow", borrow, 1);
`ifdef SERIAL_SUB_OVF_EN
    check("s3_ovf", ovf, 0);
`endif
    tick();
    do_op(8'hA5, 8'h5A, 1'b0, lat);
    check("s4_diff", diff, 8'h4B);
    check("s4_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("s4_ovf", ovf, 1);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor, the counterpart to the team's full-adder datapath. It accepts two WIDTH-bit operands and a borrow-in through a valid/ready handshake. It computes a − b − bin LSB-first, one full-subtractor cell evaluation per clock, with a registered borrow. It presents the difference and borrow-out through a second valid/ready handshake. It is used where area matters more than throughput, and it chains to wider words through bin/borrow.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands a, b and bin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in; subtracted at the LSB.
- out_valid  output  1  diff/borrow valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a − b − bin, modulo 2^WIDTH.
- borrow  output  1  borrow out of the MSB; 1 when a < b + bin (unsigned).
- busy  output  1  high in SHIFT or DONE.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a and b into shift registers and bin into the borrow register, clear the bit counter, and go to SHIFT.
- SHIFT, each cycle:
  - a0 = LSB of the a shift register; b0 = LSB of the b shift register; br = the borrow register.
  - d = a0^b0^br.
  - bo = (~a0&b0) | (~(a0^b0)&br).
  - Shift d into diff at the MSB (diff shifts right). Shift the a and b registers right. Set br ← bo. Increment the counter.
  - After the WIDTH-th shift, go to DONE.
- DONE:
  - out_valid=1.
  - diff and borrow are held stable until out_valid&out_ready, then the FSM goes to IDLE.
- Counter width: $clog2(WIDTH+1). It does not wrap within an operation.
- Ignored inputs:
  - in_valid outside IDLE is ignored; the operands are not sampled.
  - out_ready outside DONE is ignored.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset (synchronous, any state): FSM → IDLE. diff, borrow, ovf, out_valid, busy and the counter → 0. in_ready → 1 on the first cycle after reset deasserts. An in-flight operation is discarded with no output.
- rst has priority over every handshake in the same cycle.

## Timing
- The accepting edge is edge T (in_valid&in_ready sampled high).
- The shifts occur at edges T+1 … T+WIDTH.
- out_valid is high after edge T+WIDTH: latency from acceptance to valid is WIDTH cycles.
- If out_ready is already high, the result handshake completes at edge T+WIDTH+1, and in_ready is high again after that edge.
- Minimum spacing between accepted operations: WIDTH+2 cycles.
- Back-pressure: while out_ready=0 in DONE, out_valid, diff, borrow and ovf hold indefinitely.
- busy falls in the same cycle in_ready rises.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - Adds output ovf, registered at the final shift.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the captured operand MSBs.
  - ovf is valid with out_valid, held with the result, and reset to 0.
- SERIAL_SUB_OVF_EN undefined: the ovf port and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, a=0x35, b=0x12, bin=0, out_ready=1 → out_valid 8 cycles after accept, diff=0x23, borrow=0, in_ready high again 1 cycle later.
- a=0x00, b=0x01, bin=0 → diff=0xFF, borrow=1; with SERIAL_SUB_OVF_EN, ovf=0.
- a=0x10, b=0x10, bin=1 → diff=0xFF, borrow=1. Chaining a low word with borrow=1 into a high word's bin yields the correct 16-bit result for 0x0100−0x0001=0x00FF.
- Hold out_ready=0 for 5 cycles in DONE, with in_valid pulsed during SHIFT and DONE:
  - diff, borrow and out_valid are stable.
  - The pulsed operands are not accepted.
  - The result handshake completes on the first out_ready=1.
- Assert rst at shift 4 of 8 → next cycle all outputs 0 and in_ready=1. A following op a=0x0A, b=0x03 → diff=0x07, borrow=0, unaffected by the aborted op.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 → diff=0x7F, ovf=1, borrow=0; a=0x7F, b=0xFF → diff=0x80, ovf=1, borrow=1.
